// File: rtl/inst_fetch_resp.sv
// Instruction fetch responder: a one-entry 64-bit packet buffer in front of a
// 32-bit backing memory, refilled two words at a time on a miss.
module inst_fetch_resp #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_addr,
  output logic [63:0] fetch_data,
  output logic        fetch_stall,
  input  logic        flush,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        buf_valid_q, buf_valid_d;
  logic [28:0] buf_tag_q, buf_tag_d;
  logic [63:0] buf_data_q, buf_data_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [28:0] miss_tag_q, miss_tag_d;
  logic        drop_q, drop_d;
  logic [31:0] word0_q, word0_d;

  logic hit;
  logic ack;
  logic unused_addr_bits;

  assign unused_addr_bits = ^fetch_addr[2:0];

  assign hit         = buf_valid_q && (buf_tag_q == fetch_addr[31:3]);
  assign fetch_data  = hit ? buf_data_q : {NOP_WORD, NOP_WORD};
  assign fetch_stall = !hit;

  // Memory handshake: mem_req/mem_addr are held until a cycle with mem_ack=1,
  // which completes the read with mem_rdata; mem_ack is ignored while mem_req=0.
  assign ack      = mem_ack && mem_req_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      miss_tag_q  <= '0;
      drop_q      <= 1'b0;
      word0_q     <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      miss_tag_q  <= miss_tag_d;
      drop_q      <= drop_d;
      word0_q     <= word0_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    miss_tag_d  = miss_tag_q;
    drop_d      = drop_q;
    word0_d     = word0_q;

    case (state_q)
      IDLE: begin
        if (!hit && !flush && !inv) begin
          state_d    = RD0;
          mem_req_d  = 1'b1;
          mem_addr_d = {fetch_addr[31:3], 3'b000};
          miss_tag_d = fetch_addr[31:3];
          drop_d     = 1'b0;
        end
      end
      RD0: begin
        if (ack) begin
          word0_d = mem_rdata;
          // A redirect makes the packet useless; skip the second word.
          if (drop_q || flush) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end else begin
            mem_addr_d = mem_addr_q + 32'd4;
            state_d    = RD1;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      RD1: begin
        if (ack) begin
          buf_data_d  = {word0_q, mem_rdata};
          buf_tag_d   = miss_tag_q;
          buf_valid_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = IDLE;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Invalidate wins over a fill landing on the same edge.
    if (inv) buf_valid_d = 1'b0;
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: directed fetch sequences against a wait-state
// memory model, with fetch responses checked by a queue-based monitor.
module tb_inst_fetch_resp;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [63:0] NOP2 = {NOP, NOP};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_addr;
  logic [63:0] fetch_data;
  logic        fetch_stall;
  logic        flush;
  logic        inv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'hDEAD_BEEF;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  // expected entry: {stall cycles before hit, packet}
  logic [95:0] exp_q[$];
  logic        mon_active = 1'b0;
  int          mon_cnt = 0;

  int wait_states = 0;
  int wcnt = 0;

  inst_fetch_resp #(.NOP_WORD(32'h0000_0013)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .fetch_stall(fetch_stall),
    .flush      (flush),
    .inv        (inv),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory model: word contents are a fixed function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_1111;
    else if (a == 32'h4) return 32'h2222_2222;
    else return {a[15:0], ~a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (mem_req && wcnt >= wait_states) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_word(mem_addr);
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
    end
  end

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: counts stall cycles, pops and compares when a hit is presented
  always @(negedge clk) begin
    if (mon_active) begin
      if (fetch_stall) begin
        mon_cnt++;
        check("stall_nop_data", fetch_data, NOP2);
        if (mon_cnt > 150) begin
          checks++;
          errors++;
          $display("FAIL hit_timeout: still stalled after %0d cycles", mon_cnt);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          mon_active = 1'b0;
        end
      end else begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hit: data %h with empty queue", fetch_data);
        end else begin
          logic [95:0] e;
          e = exp_q.pop_front();
          check("stall_cycles", 64'(mon_cnt), 64'(e[95:64]));
          check("hit_data", fetch_data, e[63:0]);
        end
        mon_active = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] addr, input int stalls, input logic [63:0] data);
    fetch_addr = addr;
    exp_q.push_back({32'(stalls), data});
    mon_cnt    = 0;
    mon_active = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && mon_active; i++) @(negedge clk);
    if (mon_active) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: response not seen");
      mon_active = 1'b0;
    end
    cyc();
  endtask

  task automatic suppress(input logic [31:0] addr, input logic use_inv, input logic [63:0] data);
    fetch_addr = addr;
    flush      = !use_inv;
    inv        = use_inv;
    neg();
    check("suppress_stall", 64'(fetch_stall), 64'd1);
    cyc();
    flush = 1'b0;
    inv   = 1'b0;
    issue(addr, 3, data);
    neg();
    check("suppress_no_req", 64'(mem_req), 64'd0);
    cyc();
    neg();
    check("suppress_late_req", 64'(mem_req), 64'd1);
    check("suppress_late_addr", 64'(mem_addr), 64'(addr));
    drain();
  endtask

  initial begin
    rst        = 1'b1;
    fetch_addr = 32'h0;
    flush      = 1'b0;
    inv        = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    neg();
    check("rst_stall", 64'(fetch_stall), 64'd1);
    check("rst_data", fetch_data, NOP2);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);

    // cold miss, zero-wait memory
    cyc();
    rst = 1'b0;
    issue(32'h0, 3, 64'h1111_1111_2222_2222);
    neg();
    check("cold_stall_t0", 64'(fetch_stall), 64'd1);
    cyc(); neg();
    check("cold_c1_req", 64'(mem_req), 64'd1);
    check("cold_c1_addr", 64'(mem_addr), 64'h0);
    cyc(); neg();
    check("cold_c2_req", 64'(mem_req), 64'd1);
    check("cold_c2_addr", 64'(mem_addr), 64'h4);
    cyc(); neg();
    check("cold_c3_stall", 64'(fetch_stall), 64'd0);
    check("cold_c3_data", fetch_data, 64'h1111_1111_2222_2222);
    check("cold_c3_req", 64'(mem_req), 64'd0);
    drain();

    // same packet, other word: immediate hit
    issue(32'h4, 0, 64'h1111_1111_2222_2222);
    neg();
    check("hit4_no_req", 64'(mem_req), 64'd0);
    cyc(); neg();
    check("hit4_no_req_next", 64'(mem_req), 64'd0);
    drain();

    // two wait states per word
    wait_states = 2;
    issue(32'h100, 7, 64'h0100_FEFF_0104_FEFB);
    for (int i = 0; i < 3; i++) begin
      cyc(); neg();
      check("ws_req_hold", 64'(mem_req), 64'd1);
      check("ws_addr_hold", 64'(mem_addr), 64'h100);
    end
    cyc(); neg();
    check("ws_second_addr", 64'(mem_addr), 64'h104);
    drain();

    // flush during RD0, redirect onto the buffered packet
    fetch_addr = 32'h200;
    neg();
    check("fl_miss_stall", 64'(fetch_stall), 64'd1);
    cyc();
    flush = 1'b1;
    issue(32'h100, 0, 64'h0100_FEFF_0104_FEFB);
    neg();
    check("fl_hit_stall", 64'(fetch_stall), 64'd0);
    check("fl_rd0_addr", 64'(mem_addr), 64'h200);
    cyc();
    flush = 1'b0;
    neg();
    check("fl_rd0_hold_req", 64'(mem_req), 64'd1);
    check("fl_rd0_hold_addr", 64'(mem_addr), 64'h200);
    cyc(); neg();
    check("fl_rd0_ack_req", 64'(mem_req), 64'd1);
    cyc(); neg();
    check("fl_no_second_rd", 64'(mem_req), 64'd0);
    cyc(); neg();
    check("fl_idle_req", 64'(mem_req), 64'd0);
    check("fl_idle_hit", 64'(fetch_stall), 64'd0);
    drain();

    // inv coinciding with the RD1 ack
    wait_states = 0;
    fetch_addr  = 32'h300;
    neg();
    check("inv_miss_stall", 64'(fetch_stall), 64'd1);
    cyc(); neg();
    check("inv_rd0_addr", 64'(mem_addr), 64'h300);
    cyc();
    inv = 1'b1;
    neg();
    check("inv_rd1_addr", 64'(mem_addr), 64'h304);
    cyc();
    inv = 1'b0;
    issue(32'h300, 3, 64'h0300_FCFF_0304_FCFB);
    neg();
    check("inv_after_stall", 64'(fetch_stall), 64'd1);
    check("inv_after_req", 64'(mem_req), 64'd0);
    cyc(); neg();
    check("inv_refill_req", 64'(mem_req), 64'd1);
    check("inv_refill_addr", 64'(mem_addr), 64'h300);
    drain();

    // flush and inv in IDLE hold off the fill by one cycle
    suppress(32'h500, 1'b0, 64'h0500_FAFF_0504_FAFB);
    suppress(32'h400, 1'b1, 64'h0400_FBFF_0404_FBFB);

    // top-of-memory packet and tag width
    issue(32'hFFFF_FFF8, 3, 64'hFFF8_0007_FFFC_0003);
    cyc(); neg();
    check("top_addr0", 64'(mem_addr), 64'hFFFF_FFF8);
    cyc(); neg();
    check("top_addr1", 64'(mem_addr), 64'hFFFF_FFFC);
    drain();
    issue(32'hFFFF_FFFC, 0, 64'hFFF8_0007_FFFC_0003);
    drain();
    issue(32'h0, 3, 64'h1111_1111_2222_2222);
    drain();

    // reset while in RD1
    wait_states = 2;
    fetch_addr  = 32'h600;
    for (int i = 0; i < 4; i++) cyc();
    neg();
    check("rst_rd1_req", 64'(mem_req), 64'd1);
    check("rst_rd1_addr", 64'(mem_addr), 64'h604);
    rst        = 1'b1;
    fetch_addr = 32'h0;
    cyc(); neg();
    check("rst_mid_req", 64'(mem_req), 64'd0);
    check("rst_mid_stall", 64'(fetch_stall), 64'd1);
    check("rst_mid_data", fetch_data, NOP2);
    check("rst_mid_addr", 64'(mem_addr), 64'h0);
    cyc();
    rst         = 1'b0;
    wait_states = 0;
    issue(32'h0, 3, 64'h1111_1111_2222_2222);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_resp.md
INST_FETCH_RESP -- requirements
Module: inst_fetch_resp

Interface
REQ-001 The module SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_addr  in  32  fetch PC from IF; bits [2:0] ignored
- fetch_data  out  64  packet; [63:32] = word at {A[31:3],3'b000}, [31:0] = word at {A[31:3],3'b100}
- fetch_stall  out  1  drives IF stop; 1 = fetch_data not valid for fetch_addr
- flush  in  1  branch redirect (IF branch_flag)
- inv  in  1  invalidate packet buffer (fence.i)
- mem_req  out  1  backing-memory read request, registered
- mem_addr  out  32  word address of request, registered, bits [1:0] = 0
- mem_rdata  in  32  read data, valid when mem_ack = 1
- mem_ack  in  1  read completes this cycle
REQ-003 Parameter NOP_WORD, default 32'h0000_0013, is the filler instruction driven while stalled.

Function
REQ-004 One-entry packet buffer SHALL hold buf_valid, buf_tag[31:3] and buf_data[63:0].
REQ-005 hit = buf_valid && (buf_tag == fetch_addr[31:3]), combinational.
REQ-006 On hit: fetch_data = buf_data and fetch_stall = 0, in the same cycle, regardless of FSM state.
REQ-007 On miss: fetch_stall = 1 and fetch_data = {NOP_WORD,NOP_WORD}.
REQ-008 FSM states SHALL be IDLE, RD0 and RD1.
REQ-009 IDLE & miss & !flush & !inv:
- next state RD0, mem_req <= 1
- mem_addr <= {fetch_addr[31:3],3'b000}
- miss_tag <= fetch_addr[31:3], drop <= 0
REQ-010 RD0 & mem_ack:
- word0 <= mem_rdata
- if drop or flush: mem_req <= 0, next state IDLE
- else: mem_addr <= mem_addr + 4, next state RD1
REQ-011 RD1 & mem_ack:
- buf_data <= {word0, mem_rdata}, buf_tag <= miss_tag
- buf_valid <= !inv
- mem_req <= 0, next state IDLE
REQ-012 mem_req SHALL stay 1, with mem_addr stable, until mem_ack; mem_ack is ignored while mem_req = 0.
REQ-013 flush in RD0 or RD1 without mem_ack SHALL set drop; the outstanding handshake is always completed, never abandoned.
REQ-014 flush SHALL NOT clear the buffer.
REQ-015 flush in IDLE SHALL suppress starting a fill that cycle; evaluation restarts next cycle with the new fetch_addr.
REQ-016 inv SHALL clear buf_valid at the next edge and take priority over a simultaneous RD1 fill.
REQ-017 inv in IDLE SHALL NOT start a fill that cycle.
REQ-018 A miss arising while state is not IDLE SHALL wait for IDLE; fetch_stall stays 1 meanwhile.
REQ-019 Zero-wait memory (mem_ack in the same cycle as mem_req) gives a miss penalty of 3 stall cycles: miss seen at T, hit at T+3.
REQ-020 mem_addr + 4 SHALL wrap modulo 2^32.
REQ-021 Packet {FFFF_FFF8, FFFF_FFFC} SHALL be fetched without overflow side effects.

Reset
REQ-022 rst SHALL set state IDLE, buf_valid = 0, mem_req = 0, mem_addr = 0, drop = 0, word0 = 0, buf_tag = 0, buf_data = 0.
REQ-023 Immediately after reset, fetch_stall = 1 and fetch_data = {NOP_WORD,NOP_WORD}.
REQ-024 rst asserted mid-fill SHALL abort the fill with no buffer write, and mem_req SHALL drop at the reset edge.
REQ-025 rst SHALL take priority over flush, inv and mem_ack.

Verification
REQ-026 Cold miss, zero-wait memory (word 0x0 = 0x11111111, word 0x4 = 0x22222222), fetch_addr = 0x0:
- cycle 1: mem_req = 1, mem_addr = 0x0
- cycle 2: mem_addr = 0x4
- cycle 3: fetch_stall = 0, fetch_data = 0x11111111_22222222
REQ-027 fetch_addr = 0x4 after the REQ-026 fill -> immediate hit, same data, no mem_req.
REQ-028 Memory with 2 wait states per word, miss at 0x100 -> fetch_stall high 7 cycles; mem_addr held at 0x100 until first ack.
REQ-029 flush during RD0 with fetch_addr moved to the buffered packet:
- immediate hit, fetch_stall = 0
- RD0 completes and returns to IDLE without issuing the second read
REQ-030 inv in the same cycle as the RD1 ack -> buf_valid = 0 next cycle, fetch_stall = 1, new fill begins.
REQ-031 rst asserted while in RD1 -> next cycle mem_req = 0, buf_valid = 0, fetch_stall = 1.
